phy_status_poller: RTL and testbench

- MDIO management reader for the PHY.
- Starts once the PHY reset-hold sequence finishes, i.e. when `enable` rises.
- Repeatedly issues IEEE 802.3 Clause 22 read frames to one PHY register, normally BMSR (reg 1).
- Publishes link-up and autoneg-complete status to the MAC/FIFO side; this is the receive direction of the PHY bring-up path.

---
 rtl/phy_status_poller.sv | 154 +++++++++++++++
 tb/tb_phy_status_poller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_status_poller.sv
// Clause 22 MDIO poller: reads one PHY register repeatedly and publishes link/autoneg status.
// Optional macro LINK_DEBOUNCE_EN: link_up only changes after two consecutive agreeing reads.
module phy_status_poller #(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter logic [4:0]  REG_ADDR = 5'h01,
  parameter logic [15:0] POLL_GAP = 16'd100
) (
  input  logic        init_clk,
  input  logic        reset,
  input  logic        enable,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic [15:0] status_word,
  output logic        status_valid,
  output logic        link_up,
  output logic        an_done,
  output logic        rd_err,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FRAME  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  // Driven part of the frame: preamble, ST, OP, PHYAD, REGAD (bit 0 of the frame is the MSB here)
  localparam logic [45:0] HEADER   = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, REG_ADDR};
  localparam logic [15:0] GAP_LAST = (POLL_GAP == 16'd0) ? 16'd0 : POLL_GAP - 16'd1;

  logic [1:0]  state;
  logic [5:0]  bit_cnt;
  logic        phase;
  logic [15:0] gap_cnt;
  logic [15:0] shift_reg;
  logic        ta_fail;
  logic        in_frame;
  logic [5:0]  hdr_idx;
`ifdef LINK_DEBOUNCE_EN
  logic        link_hist;
`endif

  assign in_frame = (state == ST_FRAME);
  assign hdr_idx  = 6'd45 - bit_cnt;

  // Pad-side outputs decode straight from registered state, so they only move on bit boundaries
  always_comb begin
    busy    = in_frame;
    mdc     = in_frame & phase;
    mdio_oe = in_frame && (bit_cnt < 6'd46);
    mdio_o  = mdio_oe ? HEADER[hdr_idx] : 1'b1;
  end

  always_ff @(posedge init_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 6'd0;
      phase        <= 1'b0;
      gap_cnt      <= 16'd0;
      shift_reg    <= 16'h0000;
      ta_fail      <= 1'b0;
      status_word  <= 16'h0000;
      status_valid <= 1'b0;
      link_up      <= 1'b0;
      an_done      <= 1'b0;
      rd_err       <= 1'b0;
`ifdef LINK_DEBOUNCE_EN
      link_hist    <= 1'b0;
`endif
    end else begin
      status_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_FRAME;
            bit_cnt <= 6'd0;
            phase   <= 1'b0;
            ta_fail <= 1'b0;
          end
        end

        ST_FRAME: begin
          if (!enable) begin
            state   <= ST_IDLE;
            bit_cnt <= 6'd0;
            phase   <= 1'b0;
          end else if (!phase) begin
            // This edge is the MDC rising edge, where the PHY's data is sampled
            phase <= 1'b1;
            if (bit_cnt == 6'd47 && mdio_i) begin
              ta_fail <= 1'b1;
            end
            if (bit_cnt >= 6'd48) begin
              shift_reg <= {shift_reg[14:0], mdio_i};
            end
          end else begin
            phase <= 1'b0;
            if (bit_cnt == 6'd63) begin
              state   <= ST_UPDATE;
              bit_cnt <= 6'd0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        ST_UPDATE: begin
          state   <= ST_GAP;
          gap_cnt <= 16'd0;
          if (ta_fail) begin
            rd_err  <= 1'b1;
            link_up <= 1'b0;
`ifdef LINK_DEBOUNCE_EN
            link_hist <= 1'b0;
`endif
          end else begin
            status_word  <= shift_reg;
            status_valid <= 1'b1;
            rd_err       <= 1'b0;
            an_done      <= shift_reg[5];
`ifdef LINK_DEBOUNCE_EN
            if (shift_reg[2] == link_hist) begin
              link_up <= shift_reg[2];
            end
            link_hist <= shift_reg[2];
`else
            link_up <= shift_reg[2];
`endif
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= 16'd0;
            if (enable) begin
              state   <= ST_FRAME;
              bit_cnt <= 6'd0;
              phase   <= 1'b0;
              ta_fail <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_status_poller.sv
// Bench for phy_status_poller: timeline model of the poll schedule checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_phy_status_poller;

  localparam logic [4:0] PHY_ADDR = 5'h01;
  localparam logic [4:0] REG_ADDR = 5'h01;
  localparam int         GAP      = 10;

  logic        init_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b0;
  logic        mdio_i   = 1'b1;
  logic        mdc, mdio_o, mdio_oe;
  logic [15:0] status_word;
  logic        status_valid, link_up, an_done, rd_err, busy;

  always #5 init_clk = ~init_clk;

  phy_status_poller #(
    .PHY_ADDR(PHY_ADDR),
    .REG_ADDR(REG_ADDR),
    .POLL_GAP(16'(GAP))
  ) dut (
    .init_clk    (init_clk),
    .reset       (reset),
    .enable      (enable),
    .mdc         (mdc),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .mdio_i      (mdio_i),
    .status_word (status_word),
    .status_valid(status_valid),
    .link_up     (link_up),
    .an_done     (an_done),
    .rd_err      (rd_err),
    .busy        (busy)
  );

  int checks   = 0;
  int failures = 0;
  logic cmp_on = 1'b0;

  logic [15:0] phy_word    = 16'h7869;
  logic        phy_present = 1'b1;

  // Model: t is the cycle position inside one poll period (0..127 frame, 128 update, then gap)
  logic        running = 1'b0;
  int          t       = 0;
  logic [15:0] m_word  = 16'h0000;
  logic        m_valid = 1'b0;
  logic        m_link  = 1'b0;
  logic        m_an    = 1'b0;
  logic        m_err   = 1'b0;
  logic        m_hist  = 1'b0;
  logic [45:0] hdr_bits;

  initial hdr_bits = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, REG_ADDR};

  task automatic modelUpdate();
    if (phy_present) begin
      m_word  = phy_word;
      m_valid = 1'b1;
      m_err   = 1'b0;
      m_an    = phy_word[5];
`ifdef LINK_DEBOUNCE_EN
      if (m_hist == phy_word[2]) m_link = phy_word[2];
      m_hist = phy_word[2];
`else
      m_link = phy_word[2];
`endif
    end else begin
      m_err  = 1'b1;
      m_link = 1'b0;
      m_hist = 1'b0;
    end
  endtask

  always @(posedge init_clk) begin
    m_valid = 1'b0;
    if (reset) begin
      running = 1'b0; t = 0;
      m_word = 16'h0000; m_link = 1'b0; m_an = 1'b0; m_err = 1'b0; m_hist = 1'b0;
    end else if (!running) begin
      if (enable) begin running = 1'b1; t = 0; end
    end else if (t < 128 && !enable) begin
      running = 1'b0; t = 0;
    end else if (t == 128) begin
      modelUpdate();
      t = 129;
    end else if (t == 128 + GAP) begin
      if (enable) t = 0;
      else begin running = 1'b0; t = 0; end
    end else begin
      t++;
    end
  end

  // PHY: answers the turnaround with 0 and shifts its word out MSB first
  always @(negedge init_clk) begin : phy_drive
    int b;
    b = t / 2;
    if (running && t < 128 && b == 47) mdio_i = phy_present ? 1'b0 : 1'b1;
    else if (running && t < 128 && b >= 48) mdio_i = phy_present ? phy_word[63 - b] : 1'b1;
    else mdio_i = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge init_clk) begin : compare
    logic ef;
    int   b;
    if (cmp_on) begin
      ef = running && (t < 128);
      b  = t / 2;
      checkOutput("mdc",          mdc,          ef ? 32'(t % 2) : 32'd0);
      checkOutput("mdio_oe",      mdio_oe,      (ef && b < 46) ? 32'd1 : 32'd0);
      checkOutput("mdio_o",       mdio_o,       (ef && b < 46) ? 32'(hdr_bits[45 - b]) : 32'd1);
      checkOutput("busy",         busy,         ef);
      checkOutput("status_valid", status_valid, m_valid);
      checkOutput("status_word",  status_word,  m_word);
      checkOutput("link_up",      link_up,      m_link);
      checkOutput("an_done",      an_done,      m_an);
      checkOutput("rd_err",       rd_err,       m_err);
    end
  end

  task automatic applyStimulus(input logic rst, input logic en);
    @(negedge init_clk);
    reset  = rst;
    enable = en;
  endtask

  task automatic waitUpdate(input string name);
    int n;
    n = 0;
    do begin
      @(negedge init_clk);
      n++;
    end while (!(running && t == 129) && n < 400);
    checkOutput({name, "_timeout"}, (n < 400) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic waitBusy(output int m);
    m = 0;
    while (!busy && m < 400) begin
      @(negedge init_clk);
      m++;
    end
    checkOutput("busy_timeout", (m < 400) ? 32'd1 : 32'd0, 32'd1);
  endtask

  logic [15:0] dbw  [6] = '{16'h786D, 16'h7869, 16'h786D, 16'h786D, 16'h786D, 16'h786D};
  logic        dbok [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef LINK_DEBOUNCE_EN
  logic        dbl  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
  logic        dbl  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

  initial begin
    int n, m;
    logic [13:0] hdr;
    logic got;

    @(negedge init_clk);
    cmp_on = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_word",   status_word, 32'h0000);
    checkOutput("rst_busy",   busy,        32'd0);
    checkOutput("rst_oe",     mdio_oe,     32'd0);
    checkOutput("rst_mdio_o", mdio_o,      32'd1);

    // First read: header field check and enable-to-valid latency
    phy_word = 16'h7869; phy_present = 1'b1;
    applyStimulus(1'b0, 1'b1);
    n = 0; hdr = 14'd0; got = 1'b0;
    while (!got && n < 300) begin
      @(negedge init_clk);
      n++;
      if (((n - 1) % 2 == 0) && ((n - 1) / 2 >= 32) && ((n - 1) / 2 <= 45)) hdr = {hdr[12:0], mdio_o};
      if (status_valid) got = 1'b1;
    end
    checkOutput("header_bits",   hdr,         32'(14'b01_10_00001_00001));
    checkOutput("valid_latency", n - 1,       32'd129);
    checkOutput("word_7869",     status_word, 32'h7869);
    checkOutput("link_7869",     link_up,     32'd0);
    checkOutput("an_7869",       an_done,     32'd1);

    // Second read with link up; the next frame must follow after exactly GAP idle cycles
    phy_word = 16'h786D;
    waitBusy(m);
    checkOutput("gap_cycles", m, GAP);
    waitUpdate("read_786d");
`ifdef LINK_DEBOUNCE_EN
    checkOutput("link_786d", link_up, 32'd0);
`else
    checkOutput("link_786d", link_up, 32'd1);
`endif
    checkOutput("an_786d",  an_done, 32'd1);
    checkOutput("err_786d", rd_err,  32'd0);

    // Absent PHY: turnaround stays high
    phy_present = 1'b0;
    waitUpdate("no_phy");
    checkOutput("noPhy_err",  rd_err,      32'd1);
    checkOutput("noPhy_word", status_word, 32'h786D);
    checkOutput("noPhy_link", link_up,     32'd0);

    // Drop enable at bit 20 of the next frame, then re-enable
    phy_present = 1'b1;
    waitBusy(m);
    repeat (40) @(negedge init_clk);
    enable = 1'b0;
    @(negedge init_clk);
    checkOutput("abort_busy", busy,        32'd0);
    checkOutput("abort_oe",   mdio_oe,     32'd0);
    checkOutput("abort_word", status_word, 32'h786D);
    checkOutput("abort_err",  rd_err,      32'd1);
    repeat (3) @(negedge init_clk);
    enable = 1'b1;
    waitUpdate("reenable");
    checkOutput("reenable_err", rd_err, 32'd0);

    // Reset during data bit 55
    waitBusy(m);
    repeat (110) @(negedge init_clk);
    reset = 1'b1;
    phy_word = dbw[0]; phy_present = dbok[0];
    @(negedge init_clk);
    checkOutput("midrst_word",  status_word, 32'h0000);
    checkOutput("midrst_busy",  busy,        32'd0);
    checkOutput("midrst_link",  link_up,     32'd0);
    checkOutput("midrst_an",    an_done,     32'd0);
    checkOutput("midrst_mdc",   mdc,         32'd0);
    reset = 1'b0;

    // Link debounce sequence (also exercises the direct-follow behaviour in the default build)
    for (int i = 0; i < 6; i++) begin
      waitUpdate("db_read");
      checkOutput("db_link", link_up, dbl[i]);
      if (i < 5) begin
        phy_word    = dbw[i + 1];
        phy_present = dbok[i + 1];
      end
    end

    applyStimulus(1'b0, 1'b0);
    repeat (GAP + 5) @(negedge init_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
